// File: rtl/psm_pwm_scheduler_pkg.sv
// Shared state codes, default widths and small helpers for the PSM PWM scheduler.
package psm_pwm_scheduler_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STOP = 2'b10;
  localparam logic [1:0] ST_TRIP = 2'b11;

  localparam int BITS_CNT_DEF  = 11;
  localparam int BITS_DATA_DEF = 7;
  localparam int DT_MIN_DEF    = 2;
  localparam int P_MIN         = 2;

  function automatic logic st_active(input logic [1:0] s);
    return (s == ST_RUN) || (s == ST_STOP);
  endfunction
endpackage

// File: rtl/psm_pwm_scheduler_if.sv
// Control/config inputs and PSM/deadtime outputs of the scheduler, bundled as one port.
interface psm_pwm_scheduler_if
  import psm_pwm_scheduler_pkg::*;
#(
  parameter int BITS_CNT  = BITS_CNT_DEF,
  parameter int BITS_DATA = BITS_DATA_DEF
) ();
  logic                 iEN;
  logic                 iFAULT;
  logic                 iCLR;
  logic                 iLOAD;
  logic [BITS_CNT:0]    iPERIOD;
  logic [BITS_CNT:0]    iDUTY_A;
  logic [BITS_CNT:0]    iDUTY_B;
  logic [BITS_CNT:0]    iDUTY_C;
  logic [BITS_DATA:0]   iSHIFT;
  logic [2:0]           oPSM;
  logic [BITS_DATA:0]   oSHIFT;
  logic                 oGATE_EN;
  logic                 oLOAD_ACK;
  logic                 oSYNC;
  logic [1:0]           oSTATE;

  modport master (
    output iEN, iFAULT, iCLR, iLOAD, iPERIOD, iDUTY_A, iDUTY_B, iDUTY_C, iSHIFT,
    input  oPSM, oSHIFT, oGATE_EN, oLOAD_ACK, oSYNC, oSTATE
  );
  modport slave (
    input  iEN, iFAULT, iCLR, iLOAD, iPERIOD, iDUTY_A, iDUTY_B, iDUTY_C, iSHIFT,
    output oPSM, oSHIFT, oGATE_EN, oLOAD_ACK, oSYNC, oSTATE
  );
endinterface

// File: rtl/psm_pwm_scheduler_carrier.sv
// Symmetric up/down carrier 0..peak..1, 0; zero flags the 1->0 step, pk flags cnt at peak.
module psm_pwm_scheduler_carrier #(
  parameter int W = 12
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         run,
  input  logic         clr,
  input  logic [W-1:0] peak,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         pk
);
  logic up;

  assign zero = run & ~up & (cnt <= W'(1));
  assign pk   = up & (cnt >= peak);

  always_ff @(posedge CLK) begin
    if (!RSTn || clr) begin
      cnt <= '0;
      up  <= 1'b1;
    end else if (run) begin
      if (up) begin
        if (cnt >= peak) begin
          cnt <= cnt - W'(1);
          up  <= 1'b0;
        end else begin
          cnt <= cnt + W'(1);
        end
      end else if (cnt <= W'(1)) begin
        cnt <= '0;
        up  <= 1'b1;
      end else begin
        cnt <= cnt - W'(1);
      end
    end
  end
endmodule

// File: rtl/psm_pwm_scheduler.sv
// Three-leg PSM scheduler: fault-aware run FSM, double-buffered config, carrier compare.
module psm_pwm_scheduler
  import psm_pwm_scheduler_pkg::*;
#(
  parameter int BITS_CNT  = BITS_CNT_DEF,
  parameter int BITS_DATA = BITS_DATA_DEF,
  parameter int DT_MIN    = DT_MIN_DEF
) (
  input  logic              CLK,
  input  logic              RSTn,
  psm_pwm_scheduler_if.slave bus
);
  localparam int W  = BITS_CNT + 1;
  localparam int DW = BITS_DATA + 1;
  localparam logic [DW-1:0] DTM  = DW'(DT_MIN);
  localparam logic [W-1:0]  PMIN = W'(P_MIN);

  logic [1:0]          st, nxt;
  logic [W-1:0]        cnt, per_a, per_p;
  logic [2:0][W-1:0]   duty_a, duty_p;
  logic [DW-1:0]       sh_a, sh_p;
  logic                pend, zero, pk, run, clr, apply;
  logic [2:0]          cmp;

  always_comb begin
    nxt = st;
    if (bus.iFAULT) nxt = ST_TRIP;
    else begin
      case (st)
        ST_IDLE: if (bus.iEN) nxt = ST_RUN;
        ST_RUN:  if (!bus.iEN) nxt = ST_STOP;
        ST_STOP: if (bus.iEN) nxt = ST_RUN;
                 else if (zero) nxt = ST_IDLE;
        default: if (bus.iCLR) nxt = ST_IDLE;
      endcase
    end
  end

  assign run   = st_active(st);
  assign clr   = !st_active(nxt);
  // In IDLE there is no cycle to protect, so pending config lands immediately.
  assign apply = pend & ~bus.iFAULT & (zero | (st == ST_IDLE));

  psm_pwm_scheduler_carrier #(.W(W)) u_carrier (
    .CLK  (CLK),
    .RSTn (RSTn),
    .run  (run),
    .clr  (clr),
    .peak (per_a),
    .cnt  (cnt),
    .zero (zero),
    .pk   (pk)
  );

  // Masking the peak sample makes any duty >= P behave like duty == P.
  for (genvar k = 0; k < 3; k++) begin : g_leg
    assign cmp[k] = (cnt < duty_a[k]) & ~pk;
  end

  assign bus.oSHIFT = sh_a;
  assign bus.oSTATE = st;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      st            <= ST_IDLE;
      pend          <= 1'b0;
      per_p         <= '0;
      duty_p        <= '0;
      sh_p          <= '0;
      per_a         <= '1;
      duty_a        <= '0;
      sh_a          <= DTM;
      bus.oPSM      <= '0;
      bus.oGATE_EN  <= 1'b0;
      bus.oLOAD_ACK <= 1'b0;
      bus.oSYNC     <= 1'b0;
    end else begin
      st <= nxt;
      if (bus.iFAULT) pend <= 1'b0;
      else if (bus.iLOAD && st != ST_TRIP) begin
        pend   <= 1'b1;
        per_p  <= bus.iPERIOD;
        duty_p <= {bus.iDUTY_C, bus.iDUTY_B, bus.iDUTY_A};
        sh_p   <= bus.iSHIFT;
      end else if (apply) pend <= 1'b0;

      if (apply) begin
        per_a  <= (per_p < PMIN) ? PMIN : per_p;
        duty_a <= duty_p;
        sh_a   <= (sh_p < DTM) ? DTM : sh_p;
      end

      bus.oPSM      <= st_active(nxt) ? cmp : 3'b000;
      bus.oGATE_EN  <= st_active(nxt);
      bus.oLOAD_ACK <= apply;
      bus.oSYNC     <= zero & ~bus.iFAULT;
    end
  end
endmodule

// File: tb/tb_psm_pwm_scheduler.sv
// Scoreboarded bench: phase-based reference model pushes per-cycle expectations, monitor compares.
module tb_psm_pwm_scheduler;
  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  psm_pwm_scheduler_if #(.BITS_CNT(11), .BITS_DATA(7)) bus ();

  psm_pwm_scheduler #(.BITS_CNT(11), .BITS_DATA(7), .DT_MIN(2)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  typedef struct packed {
    logic [2:0] psm;
    logic [7:0] shift;
    logic       gate;
    logic       ack;
    logic       sync;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int nvec = 0;
  int errs = 0;

  // Model state: position t within the 2P-clock period rather than a counter direction.
  logic [1:0] m_st;
  int m_t, m_p, m_sh, psh, pp;
  int m_d[3];
  int pd[3];
  bit m_pend;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int cnt_m, dmin;
    logic act, nact, zero, apply, f;
    logic [1:0] nst;
    exp_t e;
    e = '0;
    f = bus.iFAULT;
    if (!RSTn) begin
      m_st = 2'b00; m_t = 0; m_p = 4095; m_d = '{0, 0, 0}; m_sh = 2; m_pend = 0;
      e.shift = 8'd2;
      q.push_back(e);
      return;
    end
    act   = (m_st == 2'b01) || (m_st == 2'b10);
    cnt_m = (m_t <= m_p) ? m_t : 2 * m_p - m_t;
    zero  = act && (m_t == 2 * m_p - 1);
    if (f) nst = 2'b11;
    else begin
      case (m_st)
        2'b00:   nst = bus.iEN ? 2'b01 : 2'b00;
        2'b01:   nst = bus.iEN ? 2'b01 : 2'b10;
        2'b10:   nst = bus.iEN ? 2'b01 : (zero ? 2'b00 : 2'b10);
        default: nst = bus.iCLR ? 2'b00 : 2'b11;
      endcase
    end
    nact = (nst == 2'b01) || (nst == 2'b10);
    for (int k = 0; k < 3; k++) begin
      dmin = (m_d[k] < m_p) ? m_d[k] : m_p;
      e.psm[k] = nact && (cnt_m < dmin);
    end
    apply = m_pend && !f && ((act && zero) || m_st == 2'b00);
    if (!nact) m_t = 0;
    else if (act) m_t = (m_t + 1) % (2 * m_p);
    if (apply) begin
      m_p  = (pp < 2) ? 2 : pp;
      m_d  = pd;
      m_sh = (psh < 2) ? 2 : psh;
    end
    if (f) m_pend = 0;
    else if (bus.iLOAD && m_st != 2'b11) begin
      pp = int'(bus.iPERIOD);
      pd[0] = int'(bus.iDUTY_A); pd[1] = int'(bus.iDUTY_B); pd[2] = int'(bus.iDUTY_C);
      psh = int'(bus.iSHIFT);
      m_pend = 1;
    end else if (apply) m_pend = 0;
    e.shift = 8'(m_sh);
    e.gate  = nact;
    e.ack   = apply;
    e.sync  = zero && !f;
    e.st    = nst;
    m_st = nst;
    q.push_back(e);
  endtask

  // Inputs are already set for the coming rising edge; model it, then move to the next falling edge.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge CLK);
    end
  endtask

  task automatic set_cfg(input int p, input int a, input int b, input int c, input int s);
    bus.iPERIOD = 12'(p); bus.iDUTY_A = 12'(a); bus.iDUTY_B = 12'(b);
    bus.iDUTY_C = 12'(c); bus.iSHIFT = 8'(s);
  endtask

  task automatic load_pulse();
    bus.iLOAD = 1'b1; cyc(); bus.iLOAD = 1'b0;
  endtask

  task automatic wait_run_t(input int tgt);
    int i;
    for (i = 0; i < 400; i++) begin
      if (m_t == tgt && m_st == 2'b01) break;
      cyc();
    end
    if (i == 400) begin
      errs++;
      $display("FAIL wait_run_t: target phase %0d not reached within 400 cycles", tgt);
    end
  endtask

  always @(posedge CLK) begin
    exp_t e, a;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{psm: bus.oPSM, shift: bus.oSHIFT, gate: bus.oGATE_EN, ack: bus.oLOAD_ACK,
            sync: bus.oSYNC, st: bus.oSTATE};
      nvec++;
      if (a !== e) begin
        errs++;
        $display("FAIL cycle @%0t: got psm=%b sh=%0d gate=%b ack=%b sync=%b st=%b, want psm=%b sh=%0d gate=%b ack=%b sync=%b st=%b",
                 $time, a.psm, a.shift, a.gate, a.ack, a.sync, a.st,
                 e.psm, e.shift, e.gate, e.ack, e.sync, e.st);
      end
    end
  end

  initial begin
    int c_hi, b_hi, syncs, acks;
    RSTn = 1'b0;
    bus.iEN = 0; bus.iFAULT = 0; bus.iCLR = 0; bus.iLOAD = 0;
    set_cfg(0, 0, 0, 0, 0);
    cyc(2);
    chk("reset_state", int'(bus.oSTATE), 0);
    chk("reset_shift", int'(bus.oSHIFT), 2);
    RSTn = 1'b1;

    // 1: P=10, A=5 B=0 C=10
    set_cfg(10, 5, 0, 10, 5);
    load_pulse();
    cyc();
    chk("idle_load_ack", int'(bus.oLOAD_ACK), 1);
    bus.iEN = 1'b1;
    cyc(25);
    c_hi = 0; b_hi = 0; syncs = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      c_hi += int'(bus.oPSM[2]); b_hi += int'(bus.oPSM[1]); syncs += int'(bus.oSYNC);
    end
    chk("leg_c_high_per_period", c_hi, 19);
    chk("leg_b_high_per_period", b_hi, 0);
    chk("sync_per_period", syncs, 1);

    // 2: mid-cycle load of A=3 takes effect at next zero
    wait_run_t(4);
    set_cfg(10, 3, 0, 10, 5);
    load_pulse();
    cyc(30);

    // 3: two loads before zero, latest wins, single ack, shift clamp
    wait_run_t(2);
    set_cfg(10, 7, 0, 10, 0);
    load_pulse();
    cyc(2);
    set_cfg(10, 2, 0, 10, 0);
    load_pulse();
    acks = 0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      acks += int'(bus.oLOAD_ACK);
    end
    chk("double_load_acks", acks, 1);
    chk("shift_clamped", int'(bus.oSHIFT), 2);

    // 4: fault mid-carrier with pending load, clear ignored while faulted
    wait_run_t(3);
    set_cfg(10, 8, 8, 8, 9);
    load_pulse();
    cyc(2);
    bus.iFAULT = 1'b1; bus.iCLR = 1'b1;
    cyc();
    chk("trip_state", int'(bus.oSTATE), 3);
    chk("trip_gate", int'(bus.oGATE_EN), 0);
    chk("trip_psm", int'(bus.oPSM), 0);
    bus.iCLR = 1'b0;
    cyc(2);
    bus.iFAULT = 1'b0;
    cyc(3);
    chk("trip_hold", int'(bus.oSTATE), 3);
    bus.iCLR = 1'b1;
    cyc();
    bus.iCLR = 1'b0;
    chk("trip_clear", int'(bus.oSTATE), 0);
    cyc(5);

    // 5: iEN drop at cnt=6 counting up finishes the cycle then idles
    wait_run_t(6);
    bus.iEN = 1'b0;
    cyc(13);
    chk("stop_before_zero", int'(bus.oSTATE), 2);
    cyc();
    chk("idle_after_zero", int'(bus.oSTATE), 0);
    chk("idle_psm", int'(bus.oPSM), 0);

    // 6: reset pulse mid-run, then load in IDLE
    bus.iEN = 1'b1;
    cyc(15);
    RSTn = 1'b0;
    cyc();
    chk("rst_psm", int'(bus.oPSM), 0);
    chk("rst_gate", int'(bus.oGATE_EN), 0);
    chk("rst_shift", int'(bus.oSHIFT), 2);
    RSTn = 1'b1; bus.iEN = 1'b0;
    set_cfg(12, 4, 12, 20, 6);
    load_pulse();
    cyc();
    chk("idle_ack_after_rst", int'(bus.oLOAD_ACK), 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) bus.iEN = ~bus.iEN;
      bus.iFAULT = ($urandom_range(0, 299) == 0);
      bus.iCLR   = ($urandom_range(0, 14) == 0);
      bus.iLOAD  = ($urandom_range(0, 24) == 0);
      if (bus.iLOAD)
        set_cfg($urandom_range(0, 16), $urandom_range(0, 18), $urandom_range(0, 18),
                $urandom_range(0, 18), $urandom_range(0, 255));
      RSTn = ($urandom_range(0, 799) != 0);
      cyc();
    end
    RSTn = 1'b1; bus.iLOAD = 1'b0; bus.iFAULT = 1'b0;
    cyc(2);

    repeat (3) @(posedge CLK);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
